// File: rtl/crypt_core_iter.sv
// crypt_core_iter: iterative byte XOR/rotate/shift block cipher, one round per clock.
// Encrypt and decrypt share the data register; decrypt walks the round keys in reverse.

module crypt_core_iter #(
   parameter int NBYTES = 16,
   parameter int KW     = 10,
   parameter int ROUNDS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  mode,
   input  logic [KW-1:0]         key,
   input  logic [8*NBYTES-1:0]   din,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [8*NBYTES-1:0]   dout,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                  state_q, state_d;
   logic [7:0]              r_q, r_d;
   logic [NBYTES-1:0][7:0]  data_q, data_d;
   logic [KW-1:0]           key_q, key_d;
   logic                    mode_q, mode_d;

   logic                    accept;
   logic                    last_round;
   logic [7:0]              ridx;
   logic [6:0]              rot_amt;
   logic [7:0]              rk;
   logic [7:0]              round_out [NBYTES];

   assign accept     = in_valid && in_ready;
   assign last_round = (r_q == 8'(ROUNDS-1));

   // Decrypt step j undoes encrypt round ROUNDS-1-j.
   assign ridx    = mode_q ? (8'(ROUNDS-1) - r_q) : r_q;
   assign rot_amt = 7'(32'(ridx) % KW);
   assign rk      = 8'((key_q << rot_amt) | (key_q >> (KW - 32'(rot_amt))));

   for (genvar i = 0; i < NBYTES; i++) begin : g_lane
      localparam int PREV = (i + NBYTES - 1) % NBYTES;
      localparam int NEXT = (i + 1) % NBYTES;
      logic [7:0] enc_t;
      logic [7:0] dec_t;
      // Encrypt: byte from i-1 lands here; decrypt: byte from i+1 lands here first.
      assign enc_t         = data_q[PREV] ^ rk;
      assign dec_t         = {data_q[NEXT][2:0], data_q[NEXT][7:3]};
      assign round_out[i]  = mode_q ? (dec_t ^ rk) : {enc_t[4:0], enc_t[7:5]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = RUN;
         RUN:     if (last_round) state_d = DONE;
         DONE:    if (out_ready) state_d = in_valid ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      dout      = '0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
         end
         DONE: begin
            in_ready  = out_ready;
            out_valid = 1'b1;
            dout      = data_q;
         end
         default: ;
      endcase
   end

   always_comb begin
      r_d    = r_q;
      data_d = data_q;
      key_d  = key_q;
      mode_d = mode_q;
      if (accept) begin
         r_d    = '0;
         data_d = din;
         key_d  = key;
         mode_d = mode;
      end else if (state_q == RUN) begin
         r_d = r_q + 8'd1;
         for (int i = 0; i < NBYTES; i++) data_d[i] = round_out[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q    <= '0;
         data_q <= '0;
         key_q  <= '0;
         mode_q <= 1'b0;
      end else begin
         r_q    <= r_d;
         data_q <= data_d;
         key_q  <= key_d;
         mode_q <= mode_d;
      end
   end

endmodule

// File: tb/tb_crypt_core_iter.sv
// Self-checking bench for crypt_core_iter: transaction-level model checked every cycle,
// plus directed vectors with hand-computed results.

module tb_crypt_core_iter;

   localparam int N  = 16;
   localparam int KW = 10;
   localparam int R  = 4;

   logic            clk, rst_n;
   logic            in_valid, in_ready, mode, out_valid, out_ready, busy;
   logic [KW-1:0]   key;
   logic [8*N-1:0]  din, dout;

   logic            r1_in_valid, r1_in_ready, r1_mode, r1_out_valid, r1_busy;
   logic [KW-1:0]   r1_key;
   logic [8*N-1:0]  r1_din, r1_dout;

   int vectors     = 0;
   int miscompares = 0;

   crypt_core_iter #(.NBYTES(N), .KW(KW), .ROUNDS(R)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
      .key(key), .din(din), .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
      .busy(busy)
   );

   crypt_core_iter #(.NBYTES(N), .KW(KW), .ROUNDS(1)) u_r1 (
      .clk(clk), .rst_n(rst_n), .in_valid(r1_in_valid), .in_ready(r1_in_ready), .mode(r1_mode),
      .key(r1_key), .din(r1_din), .out_valid(r1_out_valid), .out_ready(1'b1), .dout(r1_dout),
      .busy(r1_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [8*N-1:0] act, input logic [8*N-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] rotl3(input logic [7:0] v);
      return 8'((int'(v) * 8) % 256 + int'(v) / 32);
   endfunction

   function automatic logic [7:0] rotr3(input logic [7:0] v);
      return 8'(int'(v) / 8 + (int'(v) % 8) * 32);
   endfunction

   // Whole-block cipher computed directly from the round rules.
   function automatic logic [8*N-1:0] model(input bit m, input logic [KW-1:0] k,
                                            input logic [8*N-1:0] x);
      logic [7:0] b [N];
      logic [7:0] t [N];
      logic [7:0] rk;
      logic [8*N-1:0] y;
      int r, s;
      for (int i = 0; i < N; i++) b[i] = x[8*i +: 8];
      for (int j = 0; j < R; j++) begin
         r = m ? R - 1 - j : j;
         s = r % KW;
         for (int q = 0; q < 8; q++) rk[q] = k[(q - s + KW) % KW];
         if (!m) begin
            for (int i = 0; i < N; i++) t[(i + 1) % N] = rotl3(b[i] ^ rk);
            for (int i = 0; i < N; i++) b[i] = t[i];
         end else begin
            for (int i = 0; i < N; i++) t[i] = b[(i + 1) % N];
            for (int i = 0; i < N; i++) b[i] = rotr3(t[i]) ^ rk;
         end
      end
      for (int i = 0; i < N; i++) y[8*i +: 8] = b[i];
      return y;
   endfunction

   // Transaction model: a block becomes visible R edges after the edge following accept.
   logic            m_busy = 1'b0, m_done = 1'b0;
   int              m_left = 0;
   logic [8*N-1:0]  m_res  = '0;
   logic            m_rdy;
   assign m_rdy = !m_busy || (m_done && out_ready);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_left <= 0;
         m_res  <= '0;
      end else begin
         if (m_busy && !m_done) begin
            m_left <= m_left - 1;
            if (m_left == 1) m_done <= 1'b1;
         end else if (m_done && out_ready) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
         end
         if (in_valid && m_rdy) begin
            m_busy <= 1'b1;
            m_done <= 1'b0;
            m_left <= R;
            m_res  <= model(mode, key, din);
         end
      end
   end

   always @(negedge clk) begin
      chk("out_valid", {127'b0, out_valid}, {127'b0, m_done});
      chk("in_ready",  {127'b0, in_ready},  {127'b0, m_rdy});
      chk("busy",      {127'b0, busy},      {127'b0, m_busy});
      chk("dout",      dout, m_done ? m_res : '0);
   end

   task automatic timeout(input string nm);
      vectors++;
      miscompares++;
      $display("FAIL %s: timeout waiting for handshake", nm);
   endtask

   // Called just after a rising edge; returns just after the accept edge.
   task automatic send(input bit m, input logic [KW-1:0] k, input logic [8*N-1:0] d);
      int n;
      mode = m; key = k; din = d; in_valid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!in_ready && n < 60);
      if (!in_ready) timeout("send");
      @(posedge clk); #1;
      in_valid = 1'b0;
      din  = {$urandom, $urandom, $urandom, $urandom};
      key  = KW'($urandom);
      mode = 1'($urandom);
   endtask

   task automatic wait_valid(input string nm);
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!out_valid && n < 60);
      if (!out_valid) timeout(nm);
   endtask

   task automatic recv(output logic [8*N-1:0] res);
      wait_valid("recv");
      res = dout;
      @(posedge clk); #1;
   endtask

   task automatic r1_wait();
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!r1_out_valid && n < 20);
      if (!r1_out_valid) timeout("r1");
   endtask

   initial begin
      logic [8*N-1:0] c, p, d;
      logic [KW-1:0]  k;
      int             edges;

      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = 1'b0; key = '0; din = '0;
      r1_in_valid = 1'b0; r1_mode = 1'b0; r1_key = '0; r1_din = '0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", {127'b0, out_valid}, '0);
      chk("rst_in_ready",  {127'b0, in_ready},  128'd1);
      chk("rst_busy",      {127'b0, busy},      '0);
      chk("rst_dout",      dout, '0);

      // Pin the model to hand-derived values.
      chk("pin_zero",  model(1'b0, 10'h000, '0), '0);
      chk("pin_byte0", model(1'b0, 10'h000, 128'h01), 128'h00000000_00000000_00000010_00000000);
      chk("pin_key1",  model(1'b0, 10'h001, '0), {16{8'h55}});
      chk("pin_dec",   model(1'b1, 10'h001, {16{8'h55}}), '0);

      // First accept on the first edge after reset release; latency counts the accept edge.
      #10;
      rst_n = 1'b1; in_valid = 1'b1; key = '0; din = '0; mode = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("first_accept", {127'b0, busy}, 128'd1);
      edges = 1;
      while (!out_valid && edges < 40) begin
         @(negedge clk);
         if (!out_valid) begin @(posedge clk); edges++; end
      end
      chk("latency", 128'(edges), 128'd5);
      chk("zero_dout", dout, '0);
      @(posedge clk); #1;

      // Directed vectors.
      send(1'b0, 10'h000, 128'h01); recv(c);
      chk("enc_byte0", c, 128'h00000000_00000000_00000010_00000000);
      send(1'b0, 10'h001, '0); recv(c);
      chk("enc_key1", c, {16{8'h55}});
      send(1'b1, 10'h001, {16{8'h55}}); recv(c);
      chk("dec_key1", c, '0);
      send(1'b0, 10'h3FF, 128'h0123456789ABCDEF_FEDCBA9876543210); recv(c);
      send(1'b1, 10'h3FF, c); recv(p);
      chk("rt_directed", p, 128'h0123456789ABCDEF_FEDCBA9876543210);

      // ROUNDS=1 instance.
      r1_key = 10'h001; r1_din = '0; r1_mode = 1'b0; r1_in_valid = 1'b1;
      @(posedge clk); #1 r1_in_valid = 1'b0;
      r1_wait();
      chk("r1_enc", r1_dout, {16{8'h08}});
      #1 r1_mode = 1'b1; r1_din = {16{8'h08}}; r1_in_valid = 1'b1;
      @(posedge clk); #1 r1_in_valid = 1'b0;
      r1_wait();
      chk("r1_dec", r1_dout, '0);
      @(posedge clk); #1;

      // Request raised during RUN waits, and is taken as the previous result drains.
      send(1'b0, 10'h155, 128'hDEADBEEF_00112233_44556677_8899AABB);
      send(1'b1, 10'h2AA, 128'hCAFEF00D_12345678_9ABCDEF0_0F1E2D3C);
      recv(c);
      chk("queued_req", c, model(1'b1, 10'h2AA, 128'hCAFEF00D_12345678_9ABCDEF0_0F1E2D3C));

      // Backpressure, then consume and accept on the same edge.
      out_ready = 1'b0;
      send(1'b0, 10'h0F0, 128'h11);
      wait_valid("bp");
      for (int i = 0; i < 10; i++) begin
         chk("bp_in_ready", {127'b0, in_ready}, '0);
         chk("bp_valid",    {127'b0, out_valid}, 128'd1);
         chk("bp_dout",     dout, model(1'b0, 10'h0F0, 128'h11));
         @(negedge clk);
      end
      #1;
      in_valid = 1'b1; mode = 1'b0; key = 10'h00F; din = 128'h22; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("b2b_busy",  {127'b0, busy}, 128'd1);
      chk("b2b_valid", {127'b0, out_valid}, '0);
      recv(c);
      chk("b2b_res", c, model(1'b0, 10'h00F, 128'h22));

      // Inputs churning during RUN must not matter.
      send(1'b0, 10'h123, 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0);
      for (int i = 0; i < R; i++) begin
         key = ~key; mode = ~mode; din = ~din;
         @(posedge clk); #1;
      end
      recv(c);
      chk("churn", c, model(1'b0, 10'h123, 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0));

      // Reset at r=2 aborts the block.
      send(1'b0, 10'h3C3, 128'h77);
      @(posedge clk); @(posedge clk); #3;
      rst_n = 1'b0; #1;
      chk("arst_valid", {127'b0, out_valid}, '0);
      chk("arst_busy",  {127'b0, busy}, '0);
      chk("arst_ready", {127'b0, in_ready}, 128'd1);
      chk("arst_dout",  dout, '0);
      @(negedge clk); #2 rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      // Reset while DONE drops the visible result at once.
      send(1'b0, 10'h055, 128'h99);
      wait_valid("done_rst");
      #2 rst_n = 1'b0; #1;
      chk("drst_dout",  dout, '0);
      chk("drst_valid", {127'b0, out_valid}, '0);
      @(negedge clk); #2 rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      send(1'b1, 10'h2C1, 128'h0BADC0DE_0BADC0DE_0BADC0DE_0BADC0DE); recv(c);
      chk("post_rst", c, model(1'b1, 10'h2C1, 128'h0BADC0DE_0BADC0DE_0BADC0DE_0BADC0DE));

      // Random round trips.
      for (int it = 0; it < 1000; it++) begin
         k = KW'($urandom);
         d = {$urandom, $urandom, $urandom, $urandom};
         send(1'b0, k, d); recv(c);
         send(1'b1, k, c); recv(p);
         chk("roundtrip", p, d);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
